random_range_gen: RTL and testbench
===================================

RANDOM_RANGE_GEN -- requirements
Module: random_range_gen

Interface
REQ-001 SHALL have parameter OUT_W, default 4, width of the range value and sample.
REQ-002 SHALL have parameter LFSR_W, default 16, LFSR state width.
REQ-003 SHALL have parameter TAPS, default 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
REQ-004 SHALL have parameter SEED, default 16'hACE1, reset/fallback LFSR state; nonzero.
REQ-005 SHALL have parameter MIN_VAL, default 1, lowest legal output.
REQ-006 SHALL have parameter MAX_VAL, default 9, highest legal output; MIN_VAL <= MAX_VAL <= 2^OUT_W-1.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port mode  input  1  0 = sequential counter, 1 = LFSR random.
REQ-010 SHALL have port run  input  1  advance generator while high.
REQ-011 SHALL have port seed_load  input  1  load seed_in into LFSR.
REQ-012 SHALL have port seed_in  input  LFSR_W  seed value.
REQ-013 SHALL have port draw  input  1  request capture of current value.
REQ-014 SHALL have port ack  input  1  consumer accepts sample.
REQ-015 SHALL have port ran_no  output  OUT_W  current in-range value, registered.
REQ-016 SHALL have port sample  output  OUT_W  captured value, stable while sample_valid high.
REQ-017 SHALL have port sample_valid  output  1  sample holds an unconsumed capture.
REQ-018 SHALL have port overrun  output  1  sticky: draw dropped because a sample was pending.

Function
REQ-019 Counter mode, run high: ran_no SHALL become MIN_VAL if ran_no >= MAX_VAL or ran_no < MIN_VAL, else ran_no+1; LFSR holds.
REQ-020 LFSR mode, run high: lfsr SHALL step once: (lfsr >> 1) XOR (lfsr[0] ? TAPS : 0).
REQ-021 LFSR mode: candidate = low OUT_W bits of the stepped lfsr; ran_no SHALL load it if MIN_VAL <= candidate <= MAX_VAL, else hold (rejection, no modulo bias).
REQ-022 run low: ran_no and lfsr SHALL hold in both modes.
REQ-023 seed_load high SHALL set lfsr to seed_in (SEED if seed_in == 0) and override run for the LFSR that cycle; ran_no holds.
REQ-024 If lfsr is ever zero at a clock edge, it SHALL reload SEED on that edge.
REQ-025 Mode change SHALL take effect on the same edge; no state is cleared by it.
REQ-026 draw with sample_valid low SHALL capture ran_no as it was before that edge into sample and set sample_valid on that edge (1-cycle latency).
REQ-027 ack with sample_valid high SHALL clear sample_valid; ack with sample_valid low SHALL be ignored.
REQ-028 draw and ack in the same cycle with sample_valid high SHALL recapture sample and keep sample_valid high (back-to-back).
REQ-029 draw without ack while sample_valid high SHALL leave sample unchanged and set overrun; overrun clears only on reset.
REQ-030 Parameter violations (SEED == 0, MIN_VAL > MAX_VAL, MAX_VAL >= 2^OUT_W) SHALL fail elaboration.

Reset
REQ-031 reset high SHALL immediately, independent of clk, set lfsr = SEED, ran_no = MIN_VAL, sample = 0, sample_valid = 0, overrun = 0.
REQ-032 reset asserted mid-operation SHALL discard any pending sample; the first update SHALL occur on the first rising edge after reset deassertion.

Verification
REQ-033 Reset, mode=0, run high 10 cycles -> ran_no 2,3,4,5,6,7,8,9,1,2.
REQ-034 Reset, mode=1, run high 2 cycles -> lfsr 16'hE270 (candidate 0, rejected, ran_no stays 1), then 16'h7138 (ran_no = 8).
REQ-035 seed_load with seed_in = 0 and run high -> lfsr = 16'hACE1, ran_no unchanged.
REQ-036 Counter mode, ran_no = 5, draw pulse -> next cycle sample = 5, sample_valid = 1; second draw without ack -> sample stays 5, overrun = 1.
REQ-037 sample_valid high, draw+ack together while ran_no = 7 -> sample = 7, sample_valid stays 1; ack alone -> sample_valid = 0.
REQ-038 reset pulsed asynchronously between edges with sample_valid = 1 -> sample_valid, overrun = 0 and ran_no = 1 before the next clk edge.

Source files
------------

// File: rtl/random_range_gen.sv
// Range-limited value generator: sequential counter or Galois LFSR with rejection sampling,
// plus a single-entry draw/ack capture register with a sticky overrun flag.
module random_range_gen #(
  parameter int unsigned        OUT_W   = 4,
  parameter int unsigned        LFSR_W  = 16,
  parameter logic [LFSR_W-1:0]  TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0]  SEED    = 16'hACE1,
  parameter int unsigned        MIN_VAL = 1,
  parameter int unsigned        MAX_VAL = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              run,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              draw,
  input  logic              ack,
  output logic [OUT_W-1:0]  ran_no,
  output logic [OUT_W-1:0]  sample,
  output logic              sample_valid,
  output logic              overrun
);

  if (SEED == '0) begin : g_bad_seed
    $error("random_range_gen: SEED must be nonzero");
  end
  if (MIN_VAL > MAX_VAL) begin : g_bad_range
    $error("random_range_gen: MIN_VAL exceeds MAX_VAL");
  end
  if (longint'(MAX_VAL) >= (longint'(1) << OUT_W)) begin : g_bad_max
    $error("random_range_gen: MAX_VAL does not fit in OUT_W bits");
  end
  if (OUT_W > LFSR_W) begin : g_bad_width
    $error("random_range_gen: OUT_W wider than LFSR_W");
  end

  localparam logic [OUT_W-1:0] MinV = OUT_W'(MIN_VAL);
  localparam logic [OUT_W-1:0] MaxV = OUT_W'(MAX_VAL);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [OUT_W-1:0]  ran_no_q, ran_no_d, cand;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
  logic              capture;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign cand      = lfsr_step[OUT_W-1:0];

  always_comb begin
    lfsr_d   = lfsr_q;
    ran_no_d = ran_no_q;
    if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (run && mode) begin
      lfsr_d = lfsr_step;
    end
    // seed_load freezes ran_no for that cycle in either mode.
    if (run && !seed_load) begin
      if (!mode) begin
        if (ran_no_q >= MaxV || ran_no_q < MinV) begin
          ran_no_d = MinV;
        end else begin
          ran_no_d = ran_no_q + 1'b1;
        end
      end else if (lfsr_q != '0 && cand >= MinV && cand <= MaxV) begin
        ran_no_d = cand;
      end
    end
  end

  // A draw is accepted when the slot is empty or is being freed by ack on the same edge.
  assign capture = draw && (!sample_valid_q || ack);

  always_comb begin
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q | (draw && sample_valid_q && !ack);
    if (capture) begin
      sample_d       = ran_no_q;
      sample_valid_d = 1'b1;
    end else if (ack) begin
      sample_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q         <= SEED;
      ran_no_q       <= MinV;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      ran_no_q       <= ran_no_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign ran_no       = ran_no_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_random_range_gen.sv
// Directed bench for random_range_gen: ran_no/lfsr checked inline, captured samples
// checked by a queue-based monitor.
module tb_random_range_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic        run = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        draw = 1'b0;
  logic        ack = 1'b0;
  logic [3:0]  ran_no;
  logic [3:0]  sample;
  logic        sample_valid;
  logic        overrun;

  int checks = 0;
  int passes = 0;
  logic [3:0] exp_q[$];

  random_range_gen dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .run          (run),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .draw         (draw),
    .ack          (ack),
    .ran_no       (ran_no),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: each new capture shows up with sample_valid high and an expectation queued.
  always @(negedge clk) begin
    if (!reset && sample_valid && exp_q.size() > 0) begin
      chk("sample", {28'd0, sample}, {28'd0, exp_q.pop_front()});
    end
  end

  // One cycle, driven at negedge; optional expected capture pushed right after the edge.
  task automatic cyc(input logic m, input logic r, input logic sl, input logic [15:0] si,
                     input logic d, input logic a, input bit push, input logic [3:0] exp_s);
    mode = m; run = r; seed_load = sl; seed_in = si; draw = d; ack = a;
    @(posedge clk);
    if (push) exp_q.push_back(exp_s);
    @(negedge clk);
    run = 1'b0; seed_load = 1'b0; draw = 1'b0; ack = 1'b0;
  endtask

  initial begin
    logic [3:0] cnt_exp [10];
    cnt_exp = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd2};

    @(negedge clk);
    chk("reset ran_no", {28'd0, ran_no}, 32'd1);
    chk("reset sample", {28'd0, sample}, 32'd0);
    chk("reset valid", {31'd0, sample_valid}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);
    chk("reset lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
    @(negedge clk);
    reset = 1'b0;

    // Counter wrap sequence.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
      chk($sformatf("counter step %0d", i), {28'd0, ran_no}, {28'd0, cnt_exp[i]});
    end

    // LFSR mode from reset: first candidate 0 rejected, second 8 accepted.
    reset = 1'b1;
    #1 reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("lfsr step1", {16'd0, dut.lfsr_q}, 32'h0000E270);
    chk("lfsr reject", {28'd0, ran_no}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("lfsr step2", {16'd0, dut.lfsr_q}, 32'h00007138);
    chk("lfsr accept", {28'd0, ran_no}, 32'd8);

    // Zero seed falls back to SEED; ran_no holds despite run.
    cyc(1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("seed zero lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
    chk("seed ran_no hold", {28'd0, ran_no}, 32'd8);

    // Counter from 8: 9,1,2,3,4,5.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("count to 5", {28'd0, ran_no}, 32'd5);
    chk("run low hold lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);

    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 4'd5);
    chk("draw valid", {31'd0, sample_valid}, 32'd1);
    chk("no overrun yet", {31'd0, overrun}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("overrun sample", {28'd0, sample}, 32'd5);
    chk("overrun set", {31'd0, overrun}, 32'd1);

    // Advance to 7 with the sample still pending, then back-to-back draw+ack.
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("count to 7", {28'd0, ran_no}, 32'd7);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 4'd7);
    chk("b2b valid", {31'd0, sample_valid}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("ack clears", {31'd0, sample_valid}, 32'd0);
    chk("overrun sticky", {31'd0, overrun}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("ack idle ignored", {31'd0, sample_valid}, 32'd0);
    chk("ack idle sample", {28'd0, sample}, 32'd7);

    // Async reset between edges with a pending sample.
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 4'd7);
    chk("pending before reset", {31'd0, sample_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async valid", {31'd0, sample_valid}, 32'd0);
    chk("async overrun", {31'd0, overrun}, 32'd0);
    chk("async ran_no", {28'd0, ran_no}, 32'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("first step after reset", {28'd0, ran_no}, 32'd2);

    @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
